// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming KERNELxKERNEL sliding-window generator feeding the convolution engine.
// Define CONV_WIN_EOF_EN to add the frame_done end-of-frame pulse.
module conv_window_gen #(
  parameter int CL_IN = 4,
  parameter int KERNEL = 7,
  parameter int N = 4,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic [CL_IN*N-1:0] pix_in,
  input  logic en_in,
  input  logic frame_rst,
  output logic [CL_IN*KERNEL*KERNEL*N-1:0] data2conv,
  output logic en_out
`ifdef CONV_WIN_EOF_EN
  ,
  output logic frame_done
`endif
);
  localparam int PW = CL_IN*N;
  localparam int KK = KERNEL*KERNEL;
  localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W-1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H-1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL-1);
  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic hit, last;
  logic [PW-1:0] tap [KK];
  logic [CL_IN*KK*N-1:0] window;
  // frame_rst with en_in takes the same pixel as (0,0)
  assign cur_col = frame_rst ? '0 : col;
  assign cur_row = frame_rst ? '0 : row;
  assign hit = en_in && !frame_rst && row >= ROW_FIRST && col >= COL_FIRST;
  assign last = row == ROW_LAST && col == COL_LAST;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (en_in) begin
      col <= cur_col == COL_LAST ? '0 : cur_col + 1'b1;
      row <= cur_col != COL_LAST ? cur_row : cur_row == ROW_LAST ? '0 : cur_row + 1'b1;
    end else if (frame_rst) begin
      col <= '0;
      row <= '0;
    end
  if (KERNEL > 1) begin : g_win
    logic [PW-1:0] lb [KERNEL-1][IMG_W];
    logic [PW-1:0] win [KERNEL][KERNEL-1];
    logic [PW-1:0] column [KERNEL];
    // lb[0] holds the oldest line; column[KERNEL-1] is the live pixel
    always_comb begin
      column[KERNEL-1] = pix_in;
      for (int r = 0; r < KERNEL-1; r++) column[r] = lb[r][cur_col];
    end
    always_ff @(posedge clk)
      if (en_in)
        for (int r = 0; r < KERNEL; r++) begin
          if (r < KERNEL-1) lb[r][cur_col] <= column[r+1];
          for (int c = 0; c < KERNEL-2; c++) win[r][c] <= win[r][c+1];
          win[r][KERNEL-2] <= column[r];
        end
    always_comb
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL-1; c++) tap[r*KERNEL+c] = win[r][c];
        tap[r*KERNEL+KERNEL-1] = column[r];
      end
  end else begin : g_pt
    assign tap[0] = pix_in;
  end
  always_comb begin
    window = '0;
    for (int i = 0; i < CL_IN; i++)
      for (int t = 0; t < KK; t++) window[(i*KK+t)*N +: N] = tap[t][i*N +: N];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      en_out <= 1'b0;
      data2conv <= '0;
    end else begin
      en_out <= hit;
      if (hit) data2conv <= window;
    end
`ifdef CONV_WIN_EOF_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) frame_done <= 1'b0;
    else frame_done <= hit && last;
`endif
endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming sliding-window generator that feeds the convolution engine (CE). It accepts one multi-channel pixel per enabled cycle in raster order and buffers KERNEL-1 image lines plus a KERNEL×KERNEL window register per channel. For every fully populated window it emits a flattened KERNEL×KERNEL×CL_IN patch on `data2conv`, in exactly the bus layout CE consumes, with a one-cycle `en_out` strobe. It sits directly upstream of CE: `data2conv`/`en_out` connect to CE `data2conv`/`en_in`.

## Interface
- CL_IN, 4, number of input feature channels (1…49)
- KERNEL, 7, window size (1/3/5/7)
- N, 4, per-channel pixel width
- IMG_W, 32, image width in pixels (≥ KERNEL)
- IMG_H, 32, image height in lines (≥ KERNEL)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- pix_in  in  CL_IN*N  one pixel; channel i at [i*N +: N]
- en_in  in  1  pix_in valid this cycle
- frame_rst  in  1  synchronous restart to pixel (0,0)
- data2conv  out  CL_IN*KERNEL*KERNEL*N  window; channel i at [i*K*K*N +: K*K*N], tap r*KERNEL+c at [(r*KERNEL+c)*N +: N] within channel
- en_out  out  1  data2conv valid (one cycle per window)
- frame_done  out  1  present only with CONV_WIN_EOF_EN

## Operation
- Column counter col (0…IMG_W-1) and row counter row (0…IMG_H-1) advance only on en_in=1; col wraps to 0 and row increments at col=IMG_W-1; at (IMG_H-1, IMG_W-1) both wrap to 0 (next frame).
- No backpressure: CE always accepts; en_in gaps simply freeze all state.
- Per channel, KERNEL-1 line buffers of IMG_W entries, addressed by col (circular, read-before-write); the column of KERNEL pixels (buffers + pix_in) shifts into the window register.
- Tap mapping: r=0 is oldest line (row-KERNEL+1), r=KERNEL-1 is current line; c=0 is oldest column (col-KERNEL+1), c=KERNEL-1 is current pixel.
- Valid-only convolution, no padding: en_out asserted for an accepted pixel iff row ≥ KERNEL-1 and col ≥ KERNEL-1. Windows straddling a line wrap or frame boundary are never flagged. Windows per frame = (IMG_W-KERNEL+1)*(IMG_H-KERNEL+1).
- KERNEL=1: no line buffers; every accepted pixel produces en_out.
- frame_rst=1: counters cleared, en_out forced 0 next cycle; if en_in=1 same cycle, frame_rst wins and that pixel is taken as (0,0). Buffer contents are not cleared (stale data masked by the row/col gate).
- Line-buffer and window storage are not reset; their contents are don't-care until overwritten.

## Timing
- Reset (rst=0, async): col=row=0, en_out=0, data2conv=0, frame_done=0, immediately and held until rst rises.
- Latency: pixel accepted at edge k → corresponding window and en_out valid after edge k+1 (one registered stage).
- en_out high for exactly one cycle per qualifying pixel; back-to-back en_in gives back-to-back en_out within a line.
- data2conv holds its last value when en_out=0.
- Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).

## Configuration
- CONV_WIN_EOF_EN defined: port frame_done exists; it pulses high together with the en_out of the last window of a frame (pixel IMG_H-1, IMG_W-1); reset value 0; cleared by frame_rst.
- Not defined: frame_done port and its logic are absent; all other behaviour identical.

## Test plan
Parameters for all: CL_IN=2, KERNEL=3, N=4, IMG_W=8, IMG_H=6; pixel ch0=(row*8+col) mod 16, ch1=~ch0.
- 48 pixels, en_in continuous → exactly 24 en_out pulses; first one cycle after pixel (2,2) (19th pixel), ch0 tap0=0, tap4=9, tap8=2; ch1 tap0=15.
- Same frame with random 0–3 cycle en_in gaps → identical 24-window sequence, each window one cycle after its pixel.
- frame_rst asserted with pixel 30 and en_in=1 → pixel 30 treated as (0,0); no en_out until 19th pixel after restart.
- rst low for 1 cycle at pixel 25 → en_out=0, data2conv=0 immediately; next frame yields 24 correct windows.
- Two back-to-back frames (96 pixels) → 48 windows, none for new-frame rows 0–1 or cols 0–1.
- With CONV_WIN_EOF_EN: frame_done high exactly once per frame, coincident with the 24th en_out; without it, port absent and the same 24 windows are produced.
